// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : Program-counter generator. Selects the next fetch address from
//             sequential, branch, jump, register-jump and return targets,
//             and accepts a late correction from a downstream check stage.
//             It has an optional return-address stack (RAS) that predicts
//             jr-ra targets from earlier jal instructions.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Build option:
//    PC_GEN_RAS_EN  defined   -> RAS present. jal pushes id_pc+8 and jr-ra
//                                pops the top of the stack when it is
//                                non-empty.
//                   undefined -> no RAS. jal acts as j and jr-ra acts as jr.
//                                ras_hit=0, ras_empty=1, ras_full=0.
// ----------------------------------------------------------------------------
//  Ports:
//    clk         in   1       clock, all state updates on the rising edge
//    rst         in   1       synchronous active-high reset
//    stall       in   1       hold pc and RAS
//    pc_sel      in   3       000 seq, 001 branch, 010 j, 011 jr,
//                             100 jal, 101 jr-ra, 11x seq
//    id_pc       in   ADDR_W  PC of the instruction in ID
//    instr       in   32      instruction word in ID
//    beq_zero    in   1       branch-taken condition
//    id_real_rs  in   ADDR_W  forwarded GPR[rs]
//    fix_valid   in   1       corrected target valid (one-cycle pulse)
//    fix_target  in   ADDR_W  corrected target
//    pc          out  ADDR_W  registered current PC
//    npc         out  ADDR_W  combinational next PC
//    ras_hit     out  1       current jr-ra target comes from the RAS
//    ras_empty   out  1       registered RAS empty flag
//    ras_full    out  1       registered RAS full flag
//
//  ADDR_W must be at least 29, because the jump target keeps id_pc[ADDR_W-1:28].
// ============================================================================
module pc_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_3000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        pc_sel,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic [31:0]       instr,
  input  logic              beq_zero,
  input  logic [ADDR_W-1:0] id_real_rs,
  input  logic              fix_valid,
  input  logic [ADDR_W-1:0] fix_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              ras_hit,
  output logic              ras_empty,
  output logic              ras_full
);

  localparam logic [2:0] c_SEL_SEQ  = 3'b000;
  localparam logic [2:0] c_SEL_BR   = 3'b001;
  localparam logic [2:0] c_SEL_J    = 3'b010;
  localparam logic [2:0] c_SEL_JR   = 3'b011;
  localparam logic [2:0] c_SEL_JAL  = 3'b100;
  localparam logic [2:0] c_SEL_JRRA = 3'b101;

  // Target candidates
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_j_tgt;
  logic              w_unused_instr;

  assign w_pc_plus4 = pc + ADDR_W'(4);
  // The 16-bit word offset is sign-extended and scaled to a byte offset.
  assign w_br_off   = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign w_br_tgt   = id_pc + ADDR_W'(4) + w_br_off;
  assign w_j_tgt    = {id_pc[ADDR_W-1:28], instr[25:0], 2'b00};
  // The opcode field is decoded upstream into pc_sel.
  assign w_unused_instr = ^instr[31:26];

  // pc and the RAS only advance when no correction is pending and the
  // pipeline is not stalled.
  logic w_adv;
  assign w_adv = ~stall & ~fix_valid;

`ifdef PC_GEN_RAS_EN
  localparam int unsigned c_PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned c_CNT_W = c_PTR_W + 1;

  logic [ADDR_W-1:0]  r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_top;
  logic [c_CNT_W-1:0] r_count;
  logic               r_empty;
  logic               r_full;

  logic [c_PTR_W-1:0] w_top_inc;
  logic [c_PTR_W-1:0] w_top_dec;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic [ADDR_W-1:0]  w_ret_addr;
  logic               w_push;
  logic               w_pop;
  logic               w_hit;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_top_inc  = r_top + c_PTR_W'(1);
  assign w_top_dec  = r_top - c_PTR_W'(1);
  assign w_ret_addr = id_pc + ADDR_W'(8);
  assign w_do_push  = w_push & w_adv;
  assign w_do_pop   = w_pop & w_adv;
`else
  // Keeps the depth parameter referenced in a build that has no RAS.
  localparam int unsigned c_unused_depth = RAS_DEPTH;
`endif

  // Next-PC selection
  always_comb begin
    npc = w_pc_plus4;
`ifdef PC_GEN_RAS_EN
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_hit  = 1'b0;
`endif
    if (fix_valid) begin
      npc = fix_target;
    end else begin
      case (pc_sel)
        c_SEL_SEQ: npc = w_pc_plus4;
        c_SEL_BR:  npc = beq_zero ? w_br_tgt : w_pc_plus4;
        c_SEL_J:   npc = w_j_tgt;
        c_SEL_JR:  npc = id_real_rs;
        c_SEL_JAL: begin
          npc = w_j_tgt;
`ifdef PC_GEN_RAS_EN
          w_push = 1'b1;
`endif
        end
        c_SEL_JRRA: begin
`ifdef PC_GEN_RAS_EN
          if (!r_empty) begin
            npc   = r_ras[r_top];
            w_hit = 1'b1;
            w_pop = 1'b1;
          end else begin
            npc = id_real_rs;
          end
`else
          npc = id_real_rs;
`endif
        end
        default:   npc = w_pc_plus4;
      endcase
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (fix_valid) begin
      pc <= fix_target;
    end else if (!stall) begin
      pc <= npc;
    end
  end

`ifdef PC_GEN_RAS_EN
  // Occupancy saturates at RAS_DEPTH. A push into a full stack overwrites
  // the oldest entry, which is the slot just above the current top.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !r_full) begin
      w_count_nxt = r_count + c_CNT_W'(1);
    end else if (w_do_pop) begin
      w_count_nxt = r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_top <= w_top_inc;
      end else if (w_do_pop) begin
        r_top <= w_top_dec;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == c_CNT_W'(RAS_DEPTH));
    end
  end

  // Entry storage has no reset. Entries are never read while the stack is
  // empty.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      r_ras[w_top_inc] <= w_ret_addr;
    end
  end

  assign ras_hit   = w_hit;
  assign ras_empty = r_empty;
  assign ras_full  = r_full;
`else
  assign ras_hit   = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Purpose  : Self-checking bench for pc_gen. A driver applies directed and
//             random cycles, and a reference model pushes the expected
//             outputs into a queue. A monitor pops each entry and compares
//             it with the DUT.
//             Compile with PC_GEN_RAS_EN to check the RAS build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_gen;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

`ifdef PC_GEN_RAS_EN
  localparam bit c_RAS_EN = 1'b1;
`else
  localparam bit c_RAS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, beq_zero, fix_valid;
  logic [2:0]  pc_sel;
  logic [31:0] id_pc, instr, id_real_rs, fix_target;
  logic [31:0] pc, npc;
  logic        ras_hit, ras_empty, ras_full;

  pc_gen #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pc_sel     (pc_sel),
    .id_pc      (id_pc),
    .instr      (instr),
    .beq_zero   (beq_zero),
    .id_real_rs (id_real_rs),
    .fix_valid  (fix_valid),
    .fix_target (fix_target),
    .pc         (pc),
    .npc        (npc),
    .ras_hit    (ras_hit),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        hit;
    logic        empty;
    logic        full;
    bit          chk;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_no   = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_known = 1'b0;
  logic [31:0] m_ras[$];   // back = top of stack

  task automatic cmp(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endtask

  // One clock cycle of stimulus and the model's prediction for it
  task automatic cyc(input bit r, input bit s, input logic [2:0] sel,
                     input logic [31:0] ipc, input logic [31:0] ins,
                     input bit bz, input logic [31:0] rs,
                     input bit fv, input logic [31:0] ft);
    exp_t        e;
    logic [31:0] tgt_j, tgt_b, n;
    bit          h, psh, pp;
    @(negedge clk);
    rst = r; stall = s; pc_sel = sel; id_pc = ipc; instr = ins;
    beq_zero = bz; id_real_rs = rs; fix_valid = fv; fix_target = ft;

    tgt_j = (ipc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    tgt_b = ipc + 32'd4 + (32'($signed(ins[15:0])) * 32'd4);
    n = m_pc + 32'd4; h = 1'b0; psh = 1'b0; pp = 1'b0;
    if (fv) n = ft;
    else begin
      case (sel)
        3'b001: n = bz ? tgt_b : m_pc + 32'd4;
        3'b010: n = tgt_j;
        3'b011: n = rs;
        3'b100: begin n = tgt_j; psh = c_RAS_EN; end
        3'b101: begin
          if (c_RAS_EN && m_ras.size() > 0) begin
            n = m_ras[m_ras.size()-1]; h = 1'b1; pp = 1'b1;
          end else n = rs;
        end
        default: n = m_pc + 32'd4;
      endcase
    end

    e.pc = m_pc; e.npc = n; e.hit = h;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.chk = m_known; e.cyc = cyc_no;
    sb_q.push_back(e);
    cyc_no++;

    if (r) begin
      m_pc = RST_PC; m_ras.delete(); m_known = 1'b1;
    end else if (fv) begin
      m_pc = ft;
    end else if (!s) begin
      m_pc = n;
      if (psh) begin
        m_ras.push_back(ipc + 32'd8);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      if (pp) void'(m_ras.pop_back());
    end
  endtask

  task automatic step(input logic [2:0] sel, input logic [31:0] ipc,
                      input logic [31:0] rs);
    cyc(1'b0, 1'b0, sel, ipc, 32'h0800_0040, 1'b0, rs, 1'b0, 32'h0);
  endtask

  // Monitor: the DUT outputs settle after the negedge drive, so it samples
  // them 2 time units later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          cmp("pc",        e.cyc, pc,                 e.pc);
          cmp("npc",       e.cyc, npc,                e.npc);
          cmp("ras_hit",   e.cyc, {31'd0, ras_hit},   {31'd0, e.hit});
          cmp("ras_empty", e.cyc, {31'd0, ras_empty}, {31'd0, e.empty});
          cmp("ras_full",  e.cyc, {31'd0, ras_full},  {31'd0, e.full});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; pc_sel = 3'b000; id_pc = '0; instr = '0;
    beq_zero = 1'b0; id_real_rs = '0; fix_valid = 1'b0; fix_target = '0;

    // Reset, then sequential fetch
    cyc(1, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3'b000, 0, 0, 0, 0, 1, 32'h9999_0000);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    step(3'b111, 0, 0);

    // Branch taken and not taken
    cyc(0, 0, 3'b001, 32'h3010, 32'h1000_FFFE, 1, 0, 0, 0);
    cyc(0, 0, 3'b001, 32'h3010, 32'h1000_FFFE, 0, 0, 0, 0);

    // jal followed by jr-ra
    step(3'b100, 32'h3020, 0);
    step(3'b101, 32'h3030, 32'h5555);
    step(3'b000, 0, 0);

    // Five jals into a four-deep stack, then five returns
    for (int i = 1; i <= 5; i++) step(3'b100, 32'(i) << 8, 0);
    for (int i = 0; i < 5; i++)  step(3'b101, 32'h4000, 32'h7770);
    step(3'b000, 0, 0);

    // Correction wins over stall, then stall holds for 3 cycles
    cyc(0, 1, 3'b010, 32'h100, 32'h0800_0040, 0, 0, 1, 32'h4000);
    for (int i = 0; i < 3; i++) cyc(0, 1, 3'b100, 32'h200, 32'h0800_0040, 0, 0, 0, 0);
    step(3'b000, 0, 0);

    // jal then jr-ra; without the RAS this resolves through id_real_rs
    step(3'b100, 32'h3040, 0);
    step(3'b101, 32'h3050, 32'h6000);

    // Reset in the same cycle as a jal push discards the push
    step(3'b100, 32'h700, 0);
    cyc(1, 0, 3'b100, 32'h800, 32'h0800_0040, 0, 0, 0, 0);
    step(3'b101, 32'h900, 32'h1234);
    step(3'b000, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
          3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC, $urandom,
          1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
          ($urandom_range(0, 99) < 8), $urandom & 32'hFFFF_FFFC);
      // Bias toward call/return bursts so the stack fills and drains
      if (($urandom_range(0, 9)) == 0) begin
        for (int k = 0; k < 6; k++) step(3'b100, $urandom & 32'hFFFF_FFFC, 0);
        for (int k = 0; k < 6; k++) step(3'b101, 32'h0, $urandom & 32'hFFFF_FFFC);
      end
    end

    @(negedge clk);
    #4;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
